// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM download / CPU BRAM arbiter.
package rom_arb_pkg;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_LOAD,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } dl_entry_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dl_post_fifo.sv
// Posting FIFO for download writes; pointers carry a wrap bit to tell full from empty.
module dl_post_fifo
    import rom_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  dl_entry_t wdata,
    output dl_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW    = clog2(DEPTH);
    localparam int unsigned PTR_W = PW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;
    dl_entry_t        mem_q [DEPTH];

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        rdata = mem_q[rd_ptr_q[PW-1:0]];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares one single-port BRAM between posted ioctl download writes and CPU reads,
// and sequences the game core reset around a download.
module rom_dl_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_DEFER      = 4,
    parameter int unsigned RELEASE_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dn_active,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [DW-1:0] dn_data,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_wait,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          core_reset,
    output logic          overflow
);

    localparam int unsigned DEF_W  = clog2(MAX_DEFER + 1);
    localparam int unsigned HOLD_W = clog2(RELEASE_CYCLES + 1);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DEF_W-1:0]    defer_q, defer_d;
    logic                rd_flight_q, rd_flight_d;
    logic                cpu_valid_q, cpu_valid_d;
    logic [DW-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic                core_reset_q, core_reset_d;
    logic                overflow_q, overflow_d;

    logic                fifo_full;
    logic                fifo_empty;
    dl_entry_t           fifo_head;
    dl_entry_t           fifo_wdata;
    logic                cpu_grant;
    logic                wr_grant;

    assign fifo_wdata = '{addr: dn_addr, data: dn_data};

    dl_post_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (dn_wr),
        .pop     (wr_grant),
        .wdata   (fifo_wdata),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // One BRAM grant per cycle; a held read is ignored while its data is in flight.
    always_comb begin
        cpu_grant = ~reset & cpu_rd & ~rd_flight_q
                    & (fifo_empty | (defer_q < DEF_W'(MAX_DEFER)));
        wr_grant  = ~reset & ~cpu_grant & ~fifo_empty;
        mem_addr  = cpu_grant ? cpu_addr : fifo_head.addr;
        mem_din   = fifo_head.data;
        mem_we    = wr_grant;
        cpu_wait  = cpu_rd & ~cpu_grant;
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        defer_d      = defer_q;
        rd_flight_d  = cpu_grant;
        cpu_valid_d  = rd_flight_q;
        cpu_rdata_d  = cpu_rdata_q;
        overflow_d   = overflow_q;

        if (rd_flight_q) begin
            cpu_rdata_d = mem_dout;
        end

        if (wr_grant) begin
            defer_d = '0;
        end else if (cpu_grant && !fifo_empty && (defer_q < DEF_W'(MAX_DEFER))) begin
            defer_d = defer_q + DEF_W'(1);
        end

        if (dn_wr && fifo_full && !wr_grant) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_HOLD: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                end else if (hold_cnt_q <= HOLD_W'(1)) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!dn_active) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dn_active) begin
                    state_d = S_LOAD;
                end else if (fifo_empty && !dn_wr) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_W'(RELEASE_CYCLES);
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        core_reset_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= HOLD_W'(RELEASE_CYCLES);
            defer_q      <= '0;
            rd_flight_q  <= 1'b0;
            cpu_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            core_reset_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            defer_q      <= defer_d;
            rd_flight_q  <= rd_flight_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            core_reset_q <= core_reset_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cpu_valid  = cpu_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign core_reset = core_reset_q;
    assign overflow   = overflow_q;

endmodule
